pw_lock_ctrl: RTL and testbench
===============================

# pw_lock_ctrl

Sequencing controller for the 32-bit password comparator datapath. It collects eight 4-bit key digits into an entry buffer and owns the stored password register. It runs a one-cycle compare and drives the lock outputs: door-open window, failure count, timed lockout with alarm, and in-place password change while open. It sits between the keypad decoder (single-cycle key strobes) and the door/alarm drivers.

## Interface
- DEFAULT_PW, 32'h12345678, stored password after reset.
- MAX_TRIES, 3, consecutive failures that trigger lockout (1..15).
- OPEN_CYCLES, 500, cycles `open` stays high after a match (>=2).
- LOCK_CYCLES, 1000, lockout duration in cycles (>=2).
- clk  in  1  system clock, all logic on rising edge.
- clr  in  1  reset, synchronous, active-high.
- key_valid  in  1  one-cycle strobe; `key_digit` valid.
- key_digit  in  4  hex digit, 0x0..0xF.
- key_enter  in  1  one-cycle strobe: submit entry.
- key_cancel  in  1  one-cycle strobe: abort entry / close door.
- set_req  in  1  one-cycle strobe: request password change (honoured only in OPEN).
- open  out  1  door release, registered.
- err  out  1  one-cycle pulse on a failed attempt that does not lock out.
- alarm  out  1  high for the whole LOCK state.
- set_done  out  1  one-cycle pulse when a new password is committed.
- digit_cnt  out  4  digits currently buffered, 0..8.
- fail_cnt  out  4  consecutive failures, 0..MAX_TRIES.
- state  out  3  current state encoding (debug).

## Operation
- States and encodings: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, FAIL=4, LOCK=5, SET=6.
- Input priority when strobes coincide: key_cancel > key_enter > key_valid. Only the highest-priority strobe takes effect.
- Digit shift-in rule (ENTRY and SET): on key_valid with digit_cnt<8, buf <= {buf[27:0], key_digit} and digit_cnt++. With digit_cnt==8, extra digits are ignored.
- IDLE:
  - buf=0, digit_cnt=0.
  - key_valid -> ENTRY with the first digit shifted in, digit_cnt=1.
  - key_enter / key_cancel / set_req are ignored.
- ENTRY:
  - Digits shift in per the rule above.
  - key_cancel -> IDLE, buffer cleared; no failure counted.
  - key_enter -> CHECK.
- CHECK (exactly one cycle):
  - match = (digit_cnt==8) && (buf==pw). A short entry is always a failure.
  - On match: fail_cnt<=0 -> OPEN, timer loaded with OPEN_CYCLES-1.
  - On mismatch: fail_cnt++. If the new value equals MAX_TRIES -> LOCK with timer=LOCK_CYCLES-1; else -> FAIL.
  - The buffer is cleared on exit in all cases.
- FAIL (one cycle): err=1, then -> IDLE.
- OPEN:
  - open=1; timer decrements each cycle.
  - Timer==0 -> IDLE.
  - key_cancel -> IDLE immediately.
  - set_req -> SET (open deasserts).
  - Digits and key_enter are ignored.
- SET:
  - Digits shift in per the rule above.
  - key_enter with digit_cnt==8: pw <= buf, set_done=1 for one cycle (registered with the transition), -> IDLE.
  - key_enter with digit_cnt<8 or key_cancel: pw unchanged -> IDLE.
  - No timeout in SET.
- LOCK:
  - alarm=1; all key inputs ignored; timer decrements.
  - Timer==0: fail_cnt<=0 -> IDLE.
- Timer is a 16-bit down-counter shared by OPEN and LOCK; parameters must fit in 16 bits.
- Password compare is a full 32-bit equality of the registered buffer against the registered pw; no partial matching.

## Timing
- All outputs are registered. Reset values: open=0, err=0, alarm=0, set_done=0, digit_cnt=0, fail_cnt=0, state=IDLE. pw=DEFAULT_PW, buf=0, timer=0.
- clr asserted in any state, including mid-entry, OPEN, SET or LOCK, returns to the reset values on the next edge. A pending password change is discarded.
- key_enter sampled at edge N: state=CHECK after N. open=1 (or err=1, or alarm=1) after edge N+1.
- open is high for exactly OPEN_CYCLES cycles unless cancelled or set_req arrives.
- alarm is high for exactly LOCK_CYCLES cycles.
- A digit strobe in the same cycle as key_enter is dropped (key_enter wins).
- set_req outside OPEN has no effect.
- A new pw is usable for the next attempt: the earliest CHECK against it is two cycles after set_done.

## Test plan
- After reset: enter digits 1,2,3,4,5,6,7,8, then key_enter -> open=1 two edges after enter, held 500 cycles, fail_cnt=0.
- Enter 1,2,3,4,5,6,7,9 + enter -> err pulse, fail_cnt=1. Repeat twice -> third failure gives alarm=1 for 1000 cycles with err=0; keys ignored during the lockout; afterwards fail_cnt=0.
- Short entry 1,2,3 + enter -> failure (err, fail_cnt=1). Entering ten digits -> digit_cnt saturates at 8 and only the first 8 are kept. key_cancel mid-entry -> IDLE, fail_cnt unchanged.
- Open with 12345678, set_req, enter A,B,C,D,0,0,1,1 + enter -> set_done pulse. Then 12345678 fails and ABCD0011 opens.
- In SET, enter only 4 digits + enter -> pw stays 12345678. Also check key_cancel and key_enter in the same cycle during ENTRY -> IDLE with no failure counted.
- clr asserted during OPEN with timer mid-count, and during LOCK -> all outputs 0, state IDLE, pw back to 12345678 on the next edge.

Source files
------------

// File: rtl/pw_lock_ctrl_if.sv
// Keypad-to-lock-controller bundle: key strobes in, lock status out.
// Latency: none (wires only).
// Backpressure: none; all key inputs are single-cycle strobes.
interface pw_lock_ctrl_if;
  logic       key_valid;
  logic [3:0] key_digit;
  logic       key_enter;
  logic       key_cancel;
  logic       set_req;
  logic       open;
  logic       err;
  logic       alarm;
  logic       set_done;
  logic [3:0] digit_cnt;
  logic [3:0] fail_cnt;
  logic [2:0] state;

  // Keypad side drives the strobes and observes the lock status.
  modport master (
    output key_valid, key_digit, key_enter, key_cancel, set_req,
    input  open, err, alarm, set_done, digit_cnt, fail_cnt, state
  );

  // Controller side consumes the strobes and drives the lock status.
  modport slave (
    input  key_valid, key_digit, key_enter, key_cancel, set_req,
    output open, err, alarm, set_done, digit_cnt, fail_cnt, state
  );
endinterface

// File: rtl/pw_lock_ctrl.sv
// Password lock sequencer: 8-digit entry buffer, stored password, open/fail/lockout/change.
// Latency: key_enter at edge N -> CHECK after N -> open/err/alarm after N+1.
// Backpressure: none; strobes outside the states that use them are silently dropped.
module pw_lock_ctrl #(
  parameter logic [31:0] DEFAULT_PW  = 32'h12345678,
  parameter int          MAX_TRIES   = 3,
  parameter int          OPEN_CYCLES = 500,
  parameter int          LOCK_CYCLES = 1000
) (
  input  logic           clk,
  input  logic           clr,
  pw_lock_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ENTRY = 3'd1,
    S_CHECK = 3'd2,
    S_OPEN  = 3'd3,
    S_FAIL  = 3'd4,
    S_LOCK  = 3'd5,
    S_SET   = 3'd6
  } state_t;

  localparam logic [15:0] OPEN_LOAD = 16'(OPEN_CYCLES - 1);
  localparam logic [15:0] LOCK_LOAD = 16'(LOCK_CYCLES - 1);
  localparam logic [3:0]  TRY_LIMIT = 4'(MAX_TRIES);

  state_t      state_q;
  state_t      state_nxt;
  logic [31:0] entry_buf;
  logic [31:0] pw;
  logic [3:0]  digit_cnt;
  logic [3:0]  fail_cnt;
  logic [15:0] timer;
  logic        open_q;
  logic        err_q;
  logic        alarm_q;
  logic        set_done_q;

  // Control decisions produced alongside the next state.
  logic shift_en;
  logic buf_clr;
  logic load_open;
  logic load_lock;
  logic timer_dec;
  logic fail_up;
  logic fail_zero;
  logic commit;

  logic       match;
  logic [3:0] fail_inc;
  logic       buf_full;

  // A short entry can never match, even if the zero-padded buffer equals pw.
  assign buf_full = (digit_cnt == 4'd8);
  assign match    = buf_full && (entry_buf == pw);
  assign fail_inc = fail_cnt + 4'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (clr) state_q <= S_IDLE;
    else     state_q <= state_nxt;
  end

  // Next-state and datapath control; cancel > enter > digit when strobes coincide.
  always_comb begin
    state_nxt = state_q;
    shift_en  = 1'b0;
    buf_clr   = 1'b0;
    load_open = 1'b0;
    load_lock = 1'b0;
    timer_dec = 1'b0;
    fail_up   = 1'b0;
    fail_zero = 1'b0;
    commit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!bus.key_cancel && !bus.key_enter && bus.key_valid) begin
          shift_en  = 1'b1;
          state_nxt = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (bus.key_cancel) begin
          buf_clr   = 1'b1;
          state_nxt = S_IDLE;
        end else if (bus.key_enter) begin
          state_nxt = S_CHECK;
        end else if (bus.key_valid && !buf_full) begin
          shift_en = 1'b1;
        end
      end
      S_CHECK: begin
        buf_clr = 1'b1;
        if (match) begin
          fail_zero = 1'b1;
          load_open = 1'b1;
          state_nxt = S_OPEN;
        end else begin
          fail_up = 1'b1;
          if (fail_inc == TRY_LIMIT) begin
            load_lock = 1'b1;
            state_nxt = S_LOCK;
          end else begin
            state_nxt = S_FAIL;
          end
        end
      end
      S_FAIL: begin
        state_nxt = S_IDLE;
      end
      S_OPEN: begin
        if (bus.key_cancel) begin
          state_nxt = S_IDLE;
        end else if (bus.set_req) begin
          state_nxt = S_SET;
        end else if (timer == 16'd0) begin
          state_nxt = S_IDLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      S_SET: begin
        if (bus.key_cancel) begin
          buf_clr   = 1'b1;
          state_nxt = S_IDLE;
        end else if (bus.key_enter) begin
          buf_clr   = 1'b1;
          commit    = buf_full;
          state_nxt = S_IDLE;
        end else if (bus.key_valid && !buf_full) begin
          shift_en = 1'b1;
        end
      end
      S_LOCK: begin
        if (timer == 16'd0) begin
          fail_zero = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Entry buffer, stored password, shared window timer and failure counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      entry_buf <= 32'd0;
      digit_cnt <= 4'd0;
      pw        <= DEFAULT_PW;
      timer     <= 16'd0;
      fail_cnt  <= 4'd0;
    end else begin
      if (buf_clr) begin
        entry_buf <= 32'd0;
        digit_cnt <= 4'd0;
      end else if (shift_en) begin
        entry_buf <= {entry_buf[27:0], bus.key_digit};
        digit_cnt <= digit_cnt + 4'd1;
      end
      if (commit) pw <= entry_buf;
      if (load_open)      timer <= OPEN_LOAD;
      else if (load_lock) timer <= LOCK_LOAD;
      else if (timer_dec) timer <= timer - 16'd1;
      if (fail_zero)    fail_cnt <= 4'd0;
      else if (fail_up) fail_cnt <= fail_inc;
    end
  end

  // Status outputs registered from the next state so they align with state.
  always_ff @(posedge clk) begin
    if (clr) begin
      open_q     <= 1'b0;
      err_q      <= 1'b0;
      alarm_q    <= 1'b0;
      set_done_q <= 1'b0;
    end else begin
      open_q     <= (state_nxt == S_OPEN);
      err_q      <= (state_nxt == S_FAIL);
      alarm_q    <= (state_nxt == S_LOCK);
      set_done_q <= commit;
    end
  end

  assign bus.open      = open_q;
  assign bus.err       = err_q;
  assign bus.alarm     = alarm_q;
  assign bus.set_done  = set_done_q;
  assign bus.digit_cnt = digit_cnt;
  assign bus.fail_cnt  = fail_cnt;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_pw_lock_ctrl.sv
// Directed bench for pw_lock_ctrl: open, fail, lockout, cancel, password change, clear.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled at the same point.
// Backpressure: none; strobes are one cycle wide.
module tb_pw_lock_ctrl;
  logic clk = 1'b0;
  logic clr;
  int   vectors = 0;
  int   miscompares = 0;
  int   n;

  always #5 clk = ~clk;

  pw_lock_ctrl_if bus ();

  pw_lock_ctrl dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] d);
    bus.key_valid = 1'b1;
    bus.key_digit = d;
    tick();
    bus.key_valid = 1'b0;
  endtask

  task automatic type_code(input logic [31:0] v, input int cnt);
    for (int i = 0; i < cnt; i++) press(v[31-4*i -: 4]);
  endtask

  task automatic hit_enter();
    bus.key_enter = 1'b1;
    tick();
    bus.key_enter = 1'b0;
  endtask

  task automatic hit_cancel();
    bus.key_cancel = 1'b1;
    tick();
    bus.key_cancel = 1'b0;
  endtask

  task automatic hit_set();
    bus.set_req = 1'b1;
    tick();
    bus.set_req = 1'b0;
  endtask

  // Eight digits, enter, then one more edge: leaves us just after CHECK resolves.
  task automatic attempt(input logic [31:0] v);
    type_code(v, 8);
    hit_enter();
    tick();
  endtask

  initial begin
    bus.key_valid  = 1'b0;
    bus.key_digit  = 4'h0;
    bus.key_enter  = 1'b0;
    bus.key_cancel = 1'b0;
    bus.set_req    = 1'b0;
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;

    // Reset values
    chk("rst_open", bus.open, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_alarm", bus.alarm, 0);
    chk("rst_set_done", bus.set_done, 0);
    chk("rst_digit_cnt", bus.digit_cnt, 0);
    chk("rst_fail_cnt", bus.fail_cnt, 0);
    chk("rst_state", bus.state, 0);

    // Correct default password opens for exactly 500 cycles
    type_code(32'h12345678, 8);
    chk("entry_cnt8", bus.digit_cnt, 8);
    chk("entry_state", bus.state, 1);
    hit_enter();
    chk("check_state", bus.state, 2);
    chk("check_open", bus.open, 0);
    tick();
    chk("open_state", bus.state, 3);
    chk("open_open", bus.open, 1);
    chk("open_fail_cnt", bus.fail_cnt, 0);
    n = 0;
    for (int i = 0; i < 600; i++) begin
      if (!bus.open) break;
      n++;
      tick();
    end
    chk("open_len", n, 500);
    chk("open_end_state", bus.state, 0);

    // Three wrong attempts: two err pulses, then lockout
    attempt(32'h12345679);
    chk("fail1_state", bus.state, 4);
    chk("fail1_err", bus.err, 1);
    chk("fail1_cnt", bus.fail_cnt, 1);
    tick();
    chk("fail1_err_off", bus.err, 0);
    chk("fail1_idle", bus.state, 0);
    attempt(32'h12345679);
    chk("fail2_err", bus.err, 1);
    chk("fail2_cnt", bus.fail_cnt, 2);
    tick();
    attempt(32'h12345679);
    chk("lock_state", bus.state, 5);
    chk("lock_alarm", bus.alarm, 1);
    chk("lock_err", bus.err, 0);
    chk("lock_fail_cnt", bus.fail_cnt, 3);
    n = 0;
    for (int i = 0; i < 1100; i++) begin
      if (!bus.alarm) break;
      n++;
      bus.key_valid  = (i == 3);
      bus.key_digit  = 4'h1;
      bus.key_enter  = (i == 4);
      bus.set_req    = (i == 5);
      bus.key_cancel = (i == 6);
      tick();
    end
    bus.key_valid  = 1'b0;
    bus.key_enter  = 1'b0;
    bus.set_req    = 1'b0;
    bus.key_cancel = 1'b0;
    chk("lock_len", n, 1000);
    chk("lock_end_state", bus.state, 0);
    chk("lock_end_fail_cnt", bus.fail_cnt, 0);
    chk("lock_keys_ignored", bus.digit_cnt, 0);

    // Short entry is a failure
    type_code(32'h12300000, 3);
    hit_enter();
    tick();
    chk("short_err", bus.err, 1);
    chk("short_fail_cnt", bus.fail_cnt, 1);
    tick();

    // Cancel mid-entry: no failure counted
    type_code(32'h12000000, 2);
    chk("cancel_cnt2", bus.digit_cnt, 2);
    hit_cancel();
    chk("cancel_state", bus.state, 0);
    chk("cancel_digit_cnt", bus.digit_cnt, 0);
    chk("cancel_fail_cnt", bus.fail_cnt, 1);

    // Cancel and enter together: cancel wins
    type_code(32'h12000000, 2);
    bus.key_cancel = 1'b1;
    bus.key_enter  = 1'b1;
    tick();
    bus.key_cancel = 1'b0;
    bus.key_enter  = 1'b0;
    chk("cancel_enter_state", bus.state, 0);
    tick();
    chk("cancel_enter_err", bus.err, 0);
    chk("cancel_enter_fail_cnt", bus.fail_cnt, 1);

    // Ten digits: only the first eight are kept, so it still opens
    type_code(32'h12345678, 8);
    press(4'h9);
    press(4'hA);
    chk("sat_digit_cnt", bus.digit_cnt, 8);
    hit_enter();
    tick();
    chk("sat_open", bus.open, 1);
    chk("sat_fail_cnt", bus.fail_cnt, 0);
    hit_cancel();
    chk("open_cancel_open", bus.open, 0);
    chk("open_cancel_state", bus.state, 0);

    // Password change to ABCD0011
    attempt(32'h12345678);
    chk("chg_open", bus.open, 1);
    hit_set();
    chk("set_state", bus.state, 6);
    chk("set_open_off", bus.open, 0);
    type_code(32'hABCD0011, 8);
    hit_enter();
    chk("set_done_pulse", bus.set_done, 1);
    chk("set_done_state", bus.state, 0);
    tick();
    chk("set_done_off", bus.set_done, 0);
    attempt(32'h12345678);
    chk("old_pw_err", bus.err, 1);
    tick();
    attempt(32'hABCD0011);
    chk("new_pw_open", bus.open, 1);
    chk("new_pw_fail_cnt", bus.fail_cnt, 0);

    // Short entry in SET leaves the password alone
    hit_set();
    type_code(32'hABCD0000, 4);
    hit_enter();
    chk("short_set_done", bus.set_done, 0);
    chk("short_set_state", bus.state, 0);
    attempt(32'hABCD0011);
    chk("short_set_pw_kept", bus.open, 1);

    // Clear during OPEN restores defaults
    tick();
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_open_open", bus.open, 0);
    chk("clr_open_state", bus.state, 0);
    chk("clr_open_digit_cnt", bus.digit_cnt, 0);
    attempt(32'h12345678);
    chk("clr_open_pw_default", bus.open, 1);
    hit_cancel();

    // Clear during LOCK
    attempt(32'h00000000);
    tick();
    attempt(32'h00000000);
    tick();
    attempt(32'h00000000);
    chk("lock2_alarm", bus.alarm, 1);
    for (int i = 0; i < 5; i++) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_lock_alarm", bus.alarm, 0);
    chk("clr_lock_state", bus.state, 0);
    chk("clr_lock_fail_cnt", bus.fail_cnt, 0);
    attempt(32'h12345678);
    chk("clr_lock_pw_default", bus.open, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
